// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive-side raster decoder. It rebuilds horizontal and vertical position
// from incoming HSYNC/VSYNC and measures each line and frame length. It
// asserts LOCKED after LOCK_FRAMES consecutive frames that match the
// expected H_TOTAL x V_TOTAL raster. ERR is sticky and is set whenever lock
// is lost.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = 1056,
  parameter int unsigned V_TOTAL     = 628,
  parameter bit          SYNC_POL    = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PIX_EN,
  input  logic        HSYNC,
  input  logic        VSYNC,
  output logic [10:0] Hcnt,
  output logic [10:0] Vcnt,
  output logic [10:0] H_MEAS,
  output logic [10:0] V_MEAS,
  output logic        FRAME_START,
  output logic        LOCKED,
  output logic        ERR
);

  localparam logic [10:0] CNT_MAX   = 11'h7FF;
  localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
  localparam logic [11:0] V_TOTAL_L = 12'(V_TOTAL);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

  typedef enum logic {SEARCH, LOCK} state_t;

  state_t      state;
  logic [3:0]  good_cnt;
  logic        hs_prev, vs_prev;
  logic        v_pend;
  logic        h_seen, v_seen;
  logic        line_bad;

  logic        hs_act, vs_act;
  logic        h_edge, v_edge;
  logic        frame_start;
  logic        h_sat;
  logic [11:0] h_len, v_len;
  logic [10:0] h_meas_next, v_meas_next;
  logic        line_bad_now;
  logic        frame_meas;
  logic        frame_len_bad;
  logic        frame_good;

  // Sync levels normalised so that 1 always means "sync active".
  assign hs_act = (HSYNC == SYNC_POL);
  assign vs_act = (VSYNC == SYNC_POL);

  // Leading edges are taken only on pixel strobes.
  assign h_edge = PIX_EN & hs_act & ~hs_prev;
  assign v_edge = PIX_EN & vs_act & ~vs_prev;

  // A pending or coincident V edge promotes the next H edge to a frame start.
  assign frame_start = h_edge & (v_pend | v_edge);

  // Hcnt is about to reach its ceiling on this strobe: HSYNC has gone missing.
  assign h_sat = PIX_EN & ~h_edge & (Hcnt == CNT_MAX - 11'd1);

  // The line or frame length that ends on this edge, widened so it cannot wrap.
  assign h_len       = {1'b0, Hcnt} + 12'd1;
  assign v_len       = {1'b0, Vcnt} + 12'd1;
  assign h_meas_next = h_len[11] ? CNT_MAX : h_len[10:0];
  assign v_meas_next = v_len[11] ? CNT_MAX : v_len[10:0];

  // Judge a line only when its start edge was real (not the first after alignment).
  assign line_bad_now  = h_edge & h_seen & (h_len != H_TOTAL_L);
  assign frame_meas    = frame_start & v_seen;
  assign frame_len_bad = (v_len != V_TOTAL_L);
  // Include the line that closes on this very edge in the frame verdict.
  assign frame_good    = ~frame_len_bad & ~line_bad & ~line_bad_now;

  // Edge-detect history, position counters and the frame-start pulse.
  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the pre-edge values of the others, just like the hardware.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      v_pend      <= 1'b0;
      Hcnt        <= '0;
      Vcnt        <= '0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= frame_start;
      if (PIX_EN) begin
        hs_prev <= hs_act;
        vs_prev <= vs_act;
        if (h_edge)
          Hcnt <= '0;
        else if (Hcnt != CNT_MAX)
          Hcnt <= Hcnt + 11'd1;
        if (frame_start) begin
          Vcnt   <= '0;
          v_pend <= 1'b0;
        end else begin
          if (v_edge)
            v_pend <= 1'b1;
          if (h_edge && (Vcnt != CNT_MAX))
            Vcnt <= Vcnt + 11'd1;
        end
      end
    end
  end

  // Line and frame length measurement, alignment flags and the bad-line flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      H_MEAS   <= '0;
      V_MEAS   <= '0;
      h_seen   <= 1'b0;
      v_seen   <= 1'b0;
      line_bad <= 1'b0;
    end else if (h_edge) begin
      if (h_seen)
        H_MEAS <= h_meas_next;
      h_seen <= 1'b1;
      if (frame_start) begin
        if (v_seen)
          V_MEAS <= v_meas_next;
        v_seen   <= 1'b1;
        line_bad <= 1'b0;
      end else if (line_bad_now) begin
        line_bad <= 1'b1;
      end
    end else if (h_sat) begin
      // Timing was lost; the next edges only re-align and are not measured.
      h_seen <= 1'b0;
      v_seen <= 1'b0;
    end
  end

  // Lock state machine: count good frames in SEARCH, drop on any defect in LOCK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= SEARCH;
      good_cnt <= '0;
      LOCKED   <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (h_sat) begin
            good_cnt <= '0;
          end else if (frame_meas) begin
            if (frame_good) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) begin
                state  <= LOCK;
                LOCKED <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end
        LOCK: begin
          if (line_bad_now || (frame_meas && frame_len_bad) || h_sat) begin
            state    <= SEARCH;
            LOCKED   <= 1'b0;
            good_cnt <= '0;
            ERR      <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. Consumes HSYNC/VSYNC and a pixel-rate enable, recovers the horizontal and vertical position counters, measures line and frame totals, and declares lock when the incoming timing matches the expected 1056 x 628 raster. Used for loopback self-check of the display path and by downstream capture/overlay logic that needs position without access to the generator.

## Interface
- H_TOTAL, 1056, expected pixel clocks per line
- V_TOTAL, 628, expected lines per frame
- SYNC_POL, 1, active level of HSYNC/VSYNC (1 = active-high, 0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to assert LOCKED (1..15)

Ports:
- CLK  in  1  system clock; the only clock
- RST_N  in  1  asynchronous, active-low reset
- PIX_EN  in  1  pixel-rate strobe; all counting/sampling happens only on CLK edges where PIX_EN=1
- HSYNC  in  1  horizontal sync, synchronous to CLK
- VSYNC  in  1  vertical sync, synchronous to CLK
- Hcnt  out  11  pixel position since last HSYNC leading edge
- Vcnt  out  11  line position since frame start
- H_MEAS  out  11  last measured line length (pixels)
- V_MEAS  out  11  last measured frame length (lines)
- FRAME_START  out  1  one-CLK pulse on frame start
- LOCKED  out  1  timing matches H_TOTAL/V_TOTAL
- ERR  out  1  sticky: lock lost or HSYNC timeout; cleared only by reset

## Operation
- Sync inputs normalised by SYNC_POL. hs_prev/vs_prev registers capture normalised level on PIX_EN cycles; reset to inactive.
- H edge = PIX_EN & hs_active & !hs_prev. V edge likewise for VSYNC.
- Hcnt: on H edge -> 0; else on PIX_EN -> Hcnt+1, saturating at 2047.
- H_MEAS: on H edge, if h_seen, H_MEAS <= Hcnt+1 (saturating at 2047); h_seen set on first H edge. First edge after reset aligns only.
- V edge sets v_pend. Frame start = first H edge with v_pend set or coincident V edge. On frame start: Vcnt <= 0, v_pend cleared, FRAME_START pulses; if v_seen, V_MEAS <= Vcnt+1; v_seen set.
- Other H edges: Vcnt <= Vcnt+1, saturating at 2047.
- line_bad: set on any measured H edge with Hcnt+1 != H_TOTAL; cleared at each frame start after evaluation.
- Lock FSM, states SEARCH / LOCK:
  - SEARCH: at each measured frame start, good frame (V count == V_TOTAL and !line_bad) increments good_cnt, else good_cnt <= 0. good_cnt reaching LOCK_FRAMES -> LOCK, LOCKED=1.
  - LOCK: any bad line length on an H edge, bad frame length at frame start, or Hcnt reaching 2047 -> SEARCH, LOCKED=0, good_cnt=0, ERR=1.
  - SEARCH with Hcnt saturating: ERR unchanged, h_seen/v_seen cleared so next edges realign.

## Timing
- Reset (RST_N=0, async): Hcnt=0, Vcnt=0, H_MEAS=0, V_MEAS=0, FRAME_START=0, LOCKED=0, ERR=0, state SEARCH, good_cnt=0, flags clear.
- Latency: HSYNC active on PIX_EN cycle N -> Hcnt=0 visible after that CLK edge (1 CLK). FRAME_START, H_MEAS, V_MEAS, LOCKED update on the same edge.
- PIX_EN=0: all state holds; FRAME_START deasserts after one CLK regardless.
- Sync held active across many PIX_EN: single edge only.
- Simultaneous H and V edge: frame start on that same cycle.
- Two V edges before an H edge: one frame start.
- RST_N asserted mid-frame: immediate clear; realign from next H edge.

## Test plan
- Ideal 1056x628 raster, 96-pixel HSYNC, 2-line VSYNC, PIX_EN every 4th CLK -> H_MEAS=1056 from 2nd line, V_MEAS=628 from 2nd frame, LOCKED=1 at end of 2nd measured frame (LOCK_FRAMES=2), ERR=0.
- Locked, then one line of 1055 pixels -> LOCKED=0 and ERR=1 on that H edge; relock after 2 further good frames, ERR stays 1.
- Locked, HSYNC stopped -> Hcnt saturates at 2047, LOCKED=0, ERR=1; restore HSYNC -> Hcnt=0 one CLK after first edge.
- VSYNC leading edge coincident with HSYNC leading edge -> Vcnt=0 and FRAME_START=1 after that edge, no extra line counted.
- SYNC_POL=0 with inverted syncs -> identical counts to scenario 1.
- RST_N pulsed low mid-line at Hcnt=500 -> all outputs 0 immediately; first H_MEAS update only on second H edge.
